// File: rtl/reg_pipeline.sv
// Elastic register pipeline: nb_stages handshaked registers with per-stage
// backpressure, bubble collapsing, flush and a registered occupancy count.
module reg_pipeline #(
  parameter int nb_bits       = 32,
  parameter int nb_stages     = 3,
  parameter bit clear_on_idle = 1'b1
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [nb_bits-1:0]               data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [nb_bits-1:0]               data_o,
  output logic [$clog2(nb_stages+1)-1:0]   occupancy_o
);

  localparam int OccW = $clog2(nb_stages + 1);
  localparam int Last = nb_stages - 1;

  logic [nb_stages-1:0] valid_q, valid_d;
  logic [nb_bits-1:0]   data_q [nb_stages];
  logic [nb_bits-1:0]   data_d [nb_stages];
  logic [OccW-1:0]      occupancy_q, occupancy_d;
  logic [nb_stages-1:0] stageAdv;
  logic [nb_stages:0]   srcValid;
  logic [nb_bits-1:0]   srcData [nb_stages];
  logic                 inXfer;

  // A stage may advance if it is empty or the stage ahead of it is advancing.
  always_comb begin : advanceChain
    logic chain;
    chain    = out_ready_i;
    stageAdv = '0;
    for (int k = Last; k >= 0; k--) begin
      chain       = !valid_q[k] || chain;
      stageAdv[k] = chain;
    end
  end

  assign in_ready_o = stageAdv[0] && !flush_i;
  assign inXfer     = in_valid_i && in_ready_o;
  assign srcValid   = {valid_q, inXfer};

  always_comb begin
    srcData[0] = data_i;
    for (int k = 1; k < nb_stages; k++) begin
      srcData[k] = data_q[k-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < nb_stages; k++) begin
      data_d[k] = data_q[k];
    end
    for (int k = 0; k < nb_stages; k++) begin
      if (flush_i) begin
        valid_d[k] = 1'b0;
        if (clear_on_idle) data_d[k] = '0;
      end else if (stageAdv[k]) begin
        valid_d[k] = srcValid[k];
        if (srcValid[k]) begin
          data_d[k] = srcData[k];
        end else if (clear_on_idle) begin
          data_d[k] = '0;
        end
      end
    end
  end

  // Occupancy is registered alongside the valid bits it counts.
  always_comb begin
    occupancy_d = '0;
    for (int k = 0; k < nb_stages; k++) begin
      occupancy_d = occupancy_d + OccW'(valid_d[k]);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q     <= '0;
      occupancy_q <= '0;
      for (int k = 0; k < nb_stages; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      occupancy_q <= occupancy_d;
      for (int k = 0; k < nb_stages; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid_o = valid_q[Last];
  assign data_o      = data_q[Last];
  assign occupancy_o = occupancy_q;

endmodule

// File: tb/tb_reg_pipeline.sv
// Bench for reg_pipeline: randomized traffic on a 3-stage instance scored
// against a slot-position model, plus directed checks on a 1-stage hold-data instance.
module tb_reg_pipeline;

  localparam int N = 3;
  localparam int W = 32;

  logic clock = 1'b0;
  initial forever #5 clock = ~clock;

  logic         reset = 1'b1, flush = 1'b0, inValid = 1'b0, outReady = 1'b1;
  logic [W-1:0] dataIn = '0;
  logic         inReady, outValid;
  logic [W-1:0] dataOut;
  logic [1:0]   occ;

  logic       oneReset = 1'b1, oneFlush = 1'b0, oneInValid = 1'b0, oneOutReady = 1'b1;
  logic [7:0] oneDataIn = '0;
  logic       oneInReady, oneOutValid;
  logic [7:0] oneDataOut;
  logic [0:0] oneOcc;

  reg_pipeline #(.nb_bits(W), .nb_stages(N), .clear_on_idle(1'b1)) dut (
    .clock_i(clock), .reset_i(reset), .flush_i(flush),
    .in_valid_i(inValid), .in_ready_o(inReady), .data_i(dataIn),
    .out_valid_o(outValid), .out_ready_i(outReady), .data_o(dataOut),
    .occupancy_o(occ)
  );

  reg_pipeline #(.nb_bits(8), .nb_stages(1), .clear_on_idle(1'b0)) dutOne (
    .clock_i(clock), .reset_i(oneReset), .flush_i(oneFlush),
    .in_valid_i(oneInValid), .in_ready_o(oneInReady), .data_i(oneDataIn),
    .out_valid_o(oneOutValid), .out_ready_i(oneOutReady), .data_o(oneDataOut),
    .occupancy_o(oneOcc)
  );

  int           testCount = 0;
  int           failCount = 0;
  logic [W-1:0] expQ[$];
  int           posQ[$];
  bit           modelValid = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One cycle of main-DUT stimulus; accepted words are pushed to the scoreboard.
  task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit r,
                               input bit f, input bit rst);
    @(posedge clock);
    #1;
    reset = rst; flush = f; inValid = v; dataIn = d; outReady = r;
    #3;
    if (v && inReady && !rst) expQ.push_back(d);
  endtask

  task automatic driveOne(input bit v, input logic [7:0] d, input bit r,
                          input bit f, input bit rst);
    @(posedge clock);
    #1;
    oneReset = rst; oneFlush = f; oneInValid = v; oneDataIn = d; oneOutReady = r;
    #3;
  endtask

  // Model: each in-flight word has a slot position; words move forward one
  // slot per cycle but never onto or past the slot the word ahead ends up in.
  initial begin : monitor
    bit   expOutValid;
    int   newQ[$];
    int   lim, np;
    logic [W-1:0] popped;
    forever begin
      @(negedge clock);
      if (modelValid) begin
        expOutValid = posQ.size() > 0 && posQ[0] == N - 1;
        checkOutput("occupancy", 64'(occ), 64'(posQ.size()));
        checkOutput("out_valid", 64'(outValid), 64'(expOutValid));
        checkOutput("in_ready", 64'(inReady),
                    64'(!flush && (posQ.size() < N || outReady)));
        if (!expOutValid) begin
          checkOutput("idle_data_zero", 64'(dataOut), 64'(0));
        end else if (expQ.size() == 0) begin
          checkOutput("scoreboard_nonempty", 64'(0), 64'(1));
        end else if (outReady && !reset) begin
          popped = expQ.pop_front();
          checkOutput("scoreboard_data", 64'(dataOut), 64'(popped));
        end else begin
          checkOutput("held_data", 64'(dataOut), 64'(expQ[0]));
        end
      end
      if (reset) begin
        posQ.delete();
        expQ.delete();
        modelValid = 1'b1;
      end else if (modelValid) begin
        if (flush) begin
          posQ.delete();
          expQ.delete();
        end else begin
          newQ.delete();
          lim = outReady ? N + 1 : N;
          foreach (posQ[i]) begin
            np  = (posQ[i] + 1 < lim - 1) ? posQ[i] + 1 : lim - 1;
            lim = np;
            if (np < N) newQ.push_back(np);
          end
          if (inValid && inReady) newQ.push_back(0);
          posQ = newQ;
        end
      end
    end
  end

  initial begin : stimulus
    applyStimulus(0, '0, 1, 0, 1);
    applyStimulus(0, '0, 1, 0, 1);

    for (int i = 1; i <= 8; i++) applyStimulus(1, W'(i), 1, 0, 0);
    repeat (4) applyStimulus(0, '0, 1, 0, 0);

    applyStimulus(1, 'hA, 0, 0, 0);
    applyStimulus(1, 'hB, 0, 0, 0);
    applyStimulus(1, 'hC, 0, 0, 0);
    repeat (3) applyStimulus(1, 'hD, 0, 0, 0);
    applyStimulus(1, 'hD, 1, 0, 0);
    repeat (5) applyStimulus(0, '0, 1, 0, 0);

    applyStimulus(1, 'h5, 0, 0, 0);
    repeat (2) applyStimulus(0, '0, 0, 0, 0);
    applyStimulus(1, 'h6, 0, 0, 0);
    repeat (2) applyStimulus(0, '0, 0, 0, 0);
    repeat (4) applyStimulus(0, '0, 1, 0, 0);

    applyStimulus(1, 'h11, 0, 0, 0);
    applyStimulus(1, 'h22, 0, 0, 0);
    applyStimulus(1, 'h33, 0, 0, 0);
    applyStimulus(1, 'h99, 0, 1, 0);
    repeat (3) applyStimulus(0, '0, 1, 0, 0);

    applyStimulus(1, 'h40, 1, 0, 0);
    applyStimulus(1, 'h41, 1, 0, 0);
    applyStimulus(1, 'h42, 1, 1, 1);
    repeat (2) applyStimulus(0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, W'('h50 + i), 1, 0, 0);
    repeat (4) applyStimulus(0, '0, 1, 0, 0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
    end

    for (int i = 0; i < 60 && expQ.size() > 0; i++) applyStimulus(0, '0, 1, 0, 0);
    checkOutput("drain_empty", 64'(expQ.size()), 64'(0));

    driveOne(0, 8'h00, 1, 0, 1);
    driveOne(0, 8'h00, 1, 0, 0);
    checkOutput("one_reset_valid", 64'(oneOutValid), 64'(0));
    checkOutput("one_reset_data", 64'(oneDataOut), 64'(0));
    checkOutput("one_reset_occ", 64'(oneOcc), 64'(0));
    checkOutput("one_reset_ready", 64'(oneInReady), 64'(1));
    driveOne(1, 8'h3C, 1, 0, 0);
    checkOutput("one_empty_ready", 64'(oneInReady), 64'(1));
    driveOne(0, 8'h00, 1, 0, 0);
    checkOutput("one_3c_valid", 64'(oneOutValid), 64'(1));
    checkOutput("one_3c_data", 64'(oneDataOut), 64'(8'h3C));
    checkOutput("one_3c_occ", 64'(oneOcc), 64'(1));
    driveOne(0, 8'h00, 1, 0, 0);
    checkOutput("one_idle_valid", 64'(oneOutValid), 64'(0));
    checkOutput("one_idle_hold", 64'(oneDataOut), 64'(8'h3C));
    checkOutput("one_idle_occ", 64'(oneOcc), 64'(0));
    driveOne(1, 8'h55, 0, 0, 0);
    driveOne(1, 8'h66, 0, 0, 0);
    checkOutput("one_full_ready", 64'(oneInReady), 64'(0));
    checkOutput("one_stall_data", 64'(oneDataOut), 64'(8'h55));
    driveOne(1, 8'h66, 1, 0, 0);
    checkOutput("one_passthru_ready", 64'(oneInReady), 64'(1));
    driveOne(0, 8'h00, 0, 1, 0);
    checkOutput("one_66_data", 64'(oneDataOut), 64'(8'h66));
    checkOutput("one_flush_ready", 64'(oneInReady), 64'(0));
    driveOne(0, 8'h00, 1, 0, 0);
    checkOutput("one_flushed_valid", 64'(oneOutValid), 64'(0));
    checkOutput("one_flushed_hold", 64'(oneDataOut), 64'(8'h66));
    driveOne(1, 8'h77, 1, 1, 1);
    driveOne(0, 8'h00, 1, 0, 0);
    checkOutput("one_rst_data", 64'(oneDataOut), 64'(0));
    checkOutput("one_rst_valid", 64'(oneOutValid), 64'(0));
    checkOutput("one_rst_ready", 64'(oneInReady), 64'(1));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
